serial_deserializer: RTL and testbench
======================================

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per word (legal 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 0, meaning 0 = first received bit lands in DataOut[0], 1 = in DataOut[WIDTH-1].
REQ-003 The block SHALL have port Clock, input, 1, system clock; all state on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port SerialReady, input, 1, frame enable (asynchronous to Clock).
REQ-006 The block SHALL have port SerialClock, input, 1, serial bit clock; a bit is taken on its falling edge (asynchronous).
REQ-007 The block SHALL have port SerialData, input, 1, serial bit (asynchronous).
REQ-008 The block SHALL have port DataOut, output, WIDTH, last completed word.
REQ-009 The block SHALL have port DataValid, output, 1, DataOut holds an unconsumed word.
REQ-010 The block SHALL have port DataAck, input, 1, consumer takes the word in any cycle where DataValid=1.
REQ-011 The block SHALL have port DataWrite, output, 1, one-cycle pulse per word loaded into DataOut.
REQ-012 The block SHALL have port Overrun, output, 1, sticky flag: a completed word was dropped.
REQ-013 The block SHALL have port ParityError, output, 1, parity status of the word in DataOut.

Function
REQ-014 Sync: SerialReady, SerialClock and SerialData SHALL each pass through a 2-flop synchronizer before use.
REQ-015 Edge detect: a falling edge SHALL be the synchronized SerialClock going 1 to 0 between consecutive cycles. The bit sampled SHALL be the synchronized SerialData in that same cycle.
REQ-016 FSM states SHALL be IDLE and SHIFT, plus PARITY only when the parity build option is on.
REQ-017 IDLE SHALL go to SHIFT when synchronized SerialReady=1. SHIFT and PARITY SHALL return to IDLE when synchronized SerialReady=0.
REQ-018 On leaving SHIFT or PARITY because SerialReady dropped, the partial word SHALL be discarded and the bit counter cleared. DataOut, DataValid and Overrun SHALL be unchanged.
REQ-019 In SHIFT, each edge SHALL store one bit at the position given by MSB_FIRST and increment a counter of ceil(log2(WIDTH+1)) bits.
REQ-020 The WIDTH-th bit SHALL complete the word. The FSM SHALL then stay in SHIFT with the counter at 0; without parity, consecutive words SHALL need no gap.
REQ-021 Completion at a rising Clock edge SHALL make DataOut, DataValid=1 and DataWrite=1 visible in the next cycle. Latency from the raw SerialClock fall SHALL be 3 to 4 Clock cycles.
REQ-022 DataValid SHALL clear in the cycle after DataAck=1 is sampled with DataValid=1. DataAck while DataValid=0 SHALL be ignored.
REQ-023 Completion while DataValid=1 and DataAck=0: the new word SHALL be dropped, DataOut SHALL be held, and Overrun SHALL be set.
REQ-024 Completion in the same cycle as DataAck=1: the new word SHALL load, DataValid SHALL stay 1, DataWrite SHALL pulse, and no overrun SHALL be flagged.
REQ-025 Overrun SHALL stay set until Reset.
REQ-026 SerialClock edges in IDLE SHALL be ignored.

Reset
REQ-027 Reset SHALL force: state IDLE, counter 0, shift register 0, DataOut 0, DataValid 0, DataWrite 0, Overrun 0, ParityError 0, and all synchronizer flops 0.
REQ-028 Reset SHALL take priority over every other event, including mid-word. A SerialClock edge in the reset cycle SHALL be lost.

Configuration
REQ-029 Macro SERIAL_PARITY_EN defined: after the WIDTH data bits the FSM SHALL enter PARITY. The next edge SHALL be taken as an even-parity bit.
REQ-030 With SERIAL_PARITY_EN, the word SHALL complete on that parity edge. ParityError SHALL load together with DataOut, set to XOR of the data bits and the parity bit. The FSM SHALL return to SHIFT.
REQ-031 Macro SERIAL_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, ParityError SHALL be constant 0, and words SHALL complete per REQ-020.

Verification
REQ-032 The bench SHALL cover: WIDTH=8, MSB_FIRST=0, bits 1,0,1,1,0,0,1,0 -> DataOut=8'h4D, DataValid=1, exactly one DataWrite pulse.
REQ-033 The bench SHALL cover: same bits with MSB_FIRST=1 -> DataOut=8'hB2.
REQ-034 The bench SHALL cover: two back-to-back words 8'hA5 then 8'h3C with no DataAck -> DataOut=8'hA5, Overrun=1 and still 1 after a later DataAck.
REQ-035 The bench SHALL cover: SerialReady dropped after 5 bits, then a full word 8'h0F -> DataOut=8'h0F with no stale bits, Overrun=0.
REQ-036 The bench SHALL cover: Reset asserted mid-word after 3 bits -> all outputs 0 next cycle, and the next full word 8'hFF is received correctly.
REQ-037 The bench SHALL cover, with SERIAL_PARITY_EN: data 8'h07 plus parity 1 -> ParityError=0; data 8'h07 plus parity 0 -> ParityError=1.

Source files
------------

// File: rtl/serial_deserializer_if.sv
// Serial deserializer bus: async serial inputs on one side,
// word/valid/ack handshake with status flags on the other.
interface serial_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             SerialReady;
  logic             SerialClock;
  logic             SerialData;
  logic [WIDTH-1:0] DataOut;
  logic             DataValid;
  logic             DataAck;
  logic             DataWrite;
  logic             Overrun;
  logic             ParityError;

  modport master (
    input  SerialReady,
    input  SerialClock,
    input  SerialData,
    input  DataAck,
    output DataOut,
    output DataValid,
    output DataWrite,
    output Overrun,
    output ParityError
  );

  modport slave (
    output SerialReady,
    output SerialClock,
    output SerialData,
    output DataAck,
    input  DataOut,
    input  DataValid,
    input  DataWrite,
    input  Overrun,
    input  ParityError
  );
endinterface

// File: rtl/serial_deserializer.sv
// Serial-to-parallel word receiver with synchronizers and overrun flag.
// Define SERIAL_PARITY_EN to require an even-parity bit after each word.
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic Clock,
  input  logic Reset,
  serial_deserializer_if.master bus
);
  localparam int CW = $clog2(WIDTH + 1);

`ifdef SERIAL_PARITY_EN
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;
`else
  typedef enum logic [0:0] {
    IDLE,
    SHIFT
  } state_t;
`endif

  state_t           state;
  logic [1:0]       rdySync;
  logic [1:0]       sclkSync;
  logic [1:0]       sdatSync;
  logic             sclkPrev;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shiftReg;
  logic [WIDTH-1:0] shiftNext;
  logic [WIDTH-1:0] dataOut;
  logic             dataValid;
  logic             dataWrite;
  logic             overrun;
  logic             rdyS;
  logic             sclkS;
  logic             sdatS;
  logic             fall;
  logic             lastBit;
  logic             complete;
  logic             canLoad;
  logic [WIDTH-1:0] word;
`ifdef SERIAL_PARITY_EN
  logic             parityErr;
  logic             parNext;
`endif

  assign rdyS    = rdySync[1];
  assign sclkS   = sclkSync[1];
  assign sdatS   = sdatSync[1];
  assign fall    = sclkPrev & ~sclkS;
  assign lastBit = (cnt == CW'(WIDTH - 1));
  assign canLoad = ~dataValid | bus.DataAck;

  always_comb begin
    shiftNext = {sdatS, shiftReg[WIDTH-1:1]};
    if (MSB_FIRST)
      shiftNext = {shiftReg[WIDTH-2:0], sdatS};
  end

  always_comb begin
    complete = 1'b0;
    word     = shiftNext;
`ifdef SERIAL_PARITY_EN
    parNext  = 1'b0;
    // Word already sits whole in shiftReg; this edge carries parity.
    if (state == PARITY && rdyS && fall) begin
      complete = 1'b1;
      word     = shiftReg;
      parNext  = (^shiftReg) ^ sdatS;
    end
`else
    if (state == SHIFT && rdyS && fall && lastBit)
      complete = 1'b1;
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      rdySync   <= '0;
      sclkSync  <= '0;
      sdatSync  <= '0;
      sclkPrev  <= 1'b0;
      cnt       <= '0;
      shiftReg  <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      dataWrite <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_PARITY_EN
      parityErr <= 1'b0;
`endif
    end else begin
      rdySync   <= {rdySync[0], bus.SerialReady};
      sclkSync  <= {sclkSync[0], bus.SerialClock};
      sdatSync  <= {sdatSync[0], bus.SerialData};
      sclkPrev  <= sclkS;
      dataWrite <= 1'b0;

      if (dataValid && bus.DataAck)
        dataValid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (rdyS)
            state <= SHIFT;
        end
        SHIFT: begin
          if (!rdyS) begin
            state    <= IDLE;
            cnt      <= '0;
            shiftReg <= '0;
          end else if (fall) begin
            if (lastBit) begin
              cnt <= '0;
`ifdef SERIAL_PARITY_EN
              shiftReg <= shiftNext;
              state    <= PARITY;
`else
              shiftReg <= '0;
`endif
            end else begin
              shiftReg <= shiftNext;
              cnt      <= cnt + CW'(1);
            end
          end
        end
`ifdef SERIAL_PARITY_EN
        PARITY: begin
          cnt      <= '0;
          if (!rdyS) begin
            state    <= IDLE;
            shiftReg <= '0;
          end else if (fall) begin
            state    <= SHIFT;
            shiftReg <= '0;
          end
        end
`endif
        default: state <= IDLE;
      endcase

      // Load wins over the ack-clear above, keeping DataValid high.
      if (complete) begin
        if (canLoad) begin
          dataOut   <= word;
          dataValid <= 1'b1;
          dataWrite <= 1'b1;
`ifdef SERIAL_PARITY_EN
          parityErr <= parNext;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign bus.DataOut   = dataOut;
  assign bus.DataValid = dataValid;
  assign bus.DataWrite = dataWrite;
  assign bus.Overrun   = overrun;
`ifdef SERIAL_PARITY_EN
  assign bus.ParityError = parityErr;
`else
  assign bus.ParityError = 1'b0;
`endif
endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: LSB- and MSB-first instances
// share one serial stimulus; parity cases run when SERIAL_PARITY_EN is set.
module tb_serial_deserializer;
  logic clk;
  logic rst;
  logic ready;
  logic sclk;
  logic sdata;
  logic ack;
  int   nAssert;
  int   nFail;
  int   wr0;
  int   wr1;
  int   base0;
  int   base1;

  serial_deserializer_if #(.WIDTH(8)) bus0 ();
  serial_deserializer_if #(.WIDTH(8)) bus1 ();

  assign bus0.SerialReady = ready;
  assign bus0.SerialClock = sclk;
  assign bus0.SerialData  = sdata;
  assign bus0.DataAck     = ack;
  assign bus1.SerialReady = ready;
  assign bus1.SerialClock = sclk;
  assign bus1.SerialData  = sdata;
  assign bus1.DataAck     = ack;

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus0)
  );

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus0.DataWrite === 1'b1) wr0++;
    if (bus1.DataWrite === 1'b1) wr1++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; ackIt pulses DataAck in the completion cycle.
  task automatic sendBit(input logic b, input logic ackIt);
    sdata = b;
    sclk  = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
    if (ackIt) begin
      repeat (2) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic sendWord(input logic [7:0] w, input logic ackLast);
    logic par;
    par = 1'b0;
`ifdef SERIAL_PARITY_EN
    par = 1'b1;
`endif
    for (int i = 0; i < 8; i++)
      sendBit(w[i], ackLast && (i == 7) && !par);
`ifdef SERIAL_PARITY_EN
    sendBit(^w, ackLast);
`endif
  endtask

  task automatic pulseAck();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic snap();
    base0 = wr0;
    base1 = wr1;
  endtask

`ifdef SERIAL_PARITY_EN
  task automatic sendWordPar(input logic [7:0] w, input logic p);
    for (int i = 0; i < 8; i++)
      sendBit(w[i], 1'b0);
    sendBit(p, 1'b0);
  endtask
`endif

  initial begin
    nAssert = 0;
    nFail   = 0;
    wr0     = 0;
    wr1     = 0;
    rst     = 1'b1;
    ready   = 1'b0;
    sclk    = 1'b1;
    sdata   = 1'b0;
    ack     = 1'b0;
    repeat (3) @(negedge clk);
    check("rstDataOut", 32'(bus0.DataOut), 32'h0);
    check("rstValid", 32'(bus0.DataValid), 32'h0);
    check("rstWrite", 32'(bus0.DataWrite), 32'h0);
    check("rstOverrun", 32'(bus0.Overrun), 32'h0);
    check("rstParity", 32'(bus0.ParityError), 32'h0);
    rst   = 1'b0;
    ready = 1'b1;
    repeat (4) @(negedge clk);

    // bits 1,0,1,1,0,0,1,0 in time order
    snap();
    sendWord(8'h4D, 1'b0);
    repeat (2) @(negedge clk);
    check("lsbData", 32'(bus0.DataOut), 32'h4D);
    check("lsbValid", 32'(bus0.DataValid), 32'h1);
    check("lsbWrites", 32'(wr0 - base0), 32'h1);
    check("msbData", 32'(bus1.DataOut), 32'hB2);
    check("msbWrites", 32'(wr1 - base1), 32'h1);
    check("lsbOverrun", 32'(bus0.Overrun), 32'h0);
    pulseAck();
    check("ackClear0", 32'(bus0.DataValid), 32'h0);
    check("ackClear1", 32'(bus1.DataValid), 32'h0);

    // edges while idle must be ignored
    ready = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) sendBit(1'b1, 1'b0);
    ready = 1'b1;
    repeat (4) @(negedge clk);

    snap();
    sendWord(8'hA5, 1'b0);
    sendWord(8'h3C, 1'b0);
    repeat (2) @(negedge clk);
    check("ovrData", 32'(bus0.DataOut), 32'hA5);
    check("ovrFlag", 32'(bus0.Overrun), 32'h1);
    check("ovrWrites", 32'(wr0 - base0), 32'h1);
    pulseAck();
    check("ovrSticky", 32'(bus0.Overrun), 32'h1);
    check("ovrAckValid", 32'(bus0.DataValid), 32'h0);

    // abort after 5 bits, then a clean word
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rstOvrClr", 32'(bus0.Overrun), 32'h0);
    for (int i = 0; i < 5; i++) sendBit(1'b1, 1'b0);
    ready = 1'b0;
    repeat (4) @(negedge clk);
    ready = 1'b1;
    repeat (4) @(negedge clk);
    sendWord(8'h0F, 1'b0);
    repeat (2) @(negedge clk);
    check("abortData", 32'(bus0.DataOut), 32'h0F);
    check("abortValid", 32'(bus0.DataValid), 32'h1);
    check("abortOverrun", 32'(bus0.Overrun), 32'h0);

    // completion coincides with DataAck
    snap();
    sendWord(8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    check("coAckData", 32'(bus0.DataOut), 32'h5A);
    check("coAckValid", 32'(bus0.DataValid), 32'h1);
    check("coAckOverrun", 32'(bus0.Overrun), 32'h0);
    check("coAckWrites", 32'(wr0 - base0), 32'h1);

    // reset mid-word
    for (int i = 0; i < 3; i++) sendBit(1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midRstData", 32'(bus0.DataOut), 32'h0);
    check("midRstValid", 32'(bus0.DataValid), 32'h0);
    check("midRstWrite", 32'(bus0.DataWrite), 32'h0);
    check("midRstOverrun", 32'(bus0.Overrun), 32'h0);
    check("midRstParity", 32'(bus0.ParityError), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    snap();
    sendWord(8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    check("postRstData", 32'(bus0.DataOut), 32'hFF);
    check("postRstValid", 32'(bus0.DataValid), 32'h1);
    check("postRstWrites", 32'(wr0 - base0), 32'h1);
    check("postRstMsb", 32'(bus1.DataOut), 32'hFF);
    check("postRstOverrun", 32'(bus0.Overrun), 32'h0);
    pulseAck();

`ifdef SERIAL_PARITY_EN
    sendWordPar(8'h07, 1'b1);
    repeat (2) @(negedge clk);
    check("parGoodData", 32'(bus0.DataOut), 32'h07);
    check("parGoodErr", 32'(bus0.ParityError), 32'h0);
    pulseAck();
    sendWordPar(8'h07, 1'b0);
    repeat (2) @(negedge clk);
    check("parBadData", 32'(bus0.DataOut), 32'h07);
    check("parBadErr", 32'(bus0.ParityError), 32'h1);
    check("parBadMsb", 32'(bus1.ParityError), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end
endmodule
